// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store.
// One outstanding transaction, fixed priority with starvation guard.
package mem_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

module mem_arbiter
  import mem_pkg::*;
#(
  parameter logic       data_prio    = 1'b1,
  parameter logic [3:0] starve_limit = 4'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  mem_in_type pend_i_q, pend_i_d;
  mem_in_type pend_d_q, pend_d_d;
  logic       pend_i_valid_q, pend_i_valid_d;
  logic       pend_d_valid_q, pend_d_valid_d;
  logic [3:0] cnt_q, cnt_d;
  mem_in_type hold_q, hold_d;

  mem_in_type req_i, req_d, win;
  logic       elig_i, elig_d;
  logic       rsp, can_issue, starved;
  logic       pick_d, grant, gnt_i, gnt_d;

  // arbitration, routing and next-state
  always_comb begin
    req_i     = imem_in.mem_valid ? imem_in : pend_i_q;
    req_d     = dmem_in.mem_valid ? dmem_in : pend_d_q;
    elig_i    = imem_in.mem_valid | pend_i_valid_q;
    elig_d    = dmem_in.mem_valid | pend_d_valid_q;
    rsp       = rst & (state_q == BUSY)
              & mem_out.mem_ready;
    can_issue = rst & ((state_q == IDLE) | rsp);
    starved   = cnt_q >= starve_limit;

    // starvation hands the win to the low-priority side
    if (elig_i & elig_d)
      pick_d = data_prio ? ~starved : starved;
    else
      pick_d = elig_d;

    grant = can_issue & (elig_i | elig_d);
    gnt_i = grant & ~pick_d;
    gnt_d = grant & pick_d;

    win           = pick_d ? req_d : req_i;
    win.mem_instr = ~pick_d;
    win.mem_valid = 1'b0;

    mem_in           = grant ? win : hold_q;
    mem_in.mem_valid = grant;
    if (!rst) mem_in = '0;

    imem_out = '0;
    dmem_out = '0;
    if (rsp && owner_q == OWN_I) begin
      imem_out.mem_ready = 1'b1;
      imem_out.mem_rdata = mem_out.mem_rdata;
    end
    if (rsp && owner_q == OWN_D) begin
      dmem_out.mem_ready = 1'b1;
      dmem_out.mem_rdata = mem_out.mem_rdata;
    end

    pend_i_d = imem_in.mem_valid ? imem_in : pend_i_q;
    pend_d_d = dmem_in.mem_valid ? dmem_in : pend_d_q;
    pend_i_valid_d = (pend_i_valid_q | imem_in.mem_valid)
                   & ~gnt_i;
    pend_d_valid_d = (pend_d_valid_q | dmem_in.mem_valid)
                   & ~gnt_d;

    hold_d  = grant ? win : hold_q;
    state_d = state_q;
    owner_d = owner_q;
    if (grant) begin
      state_d = BUSY;
      owner_d = pick_d ? OWN_D : OWN_I;
    end else if (rsp) begin
      state_d = IDLE;
      owner_d = OWN_NONE;
    end

    // count consecutive priority wins over a waiting loser
    cnt_d = cnt_q;
    if (grant && pick_d != data_prio)
      cnt_d = '0;
    else if (grant && elig_i && elig_d
             && cnt_q < starve_limit)
      cnt_d = cnt_q + 4'd1;
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_NONE;
      pend_i_q       <= '0;
      pend_d_q       <= '0;
      pend_i_valid_q <= 1'b0;
      pend_d_valid_q <= 1'b0;
      cnt_q          <= '0;
      hold_q         <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      pend_i_q       <= pend_i_d;
      pend_d_q       <= pend_d_d;
      pend_i_valid_q <= pend_i_valid_d;
      pend_d_valid_q <= pend_d_valid_d;
      cnt_q          <= cnt_d;
      hold_q         <= hold_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with queued expectations,
// a latency-programmable memory responder and negedge monitors.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  mem_in_type  imem_in = '0;
  mem_in_type  dmem_in = '0;
  mem_in_type  mem_in;
  mem_out_type imem_out, dmem_out;
  mem_out_type mem_out = '0;

  int cyc = 0;
  int lat = 2;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          cyc;
    logic        instr;
    logic        fence;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } iss_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  iss_t exp_iss[$];
  rsp_t exp_i[$];
  rsp_t exp_d[$];
  rsp_t mq[$];

  mem_arbiter #(.data_prio(1'b1), .starve_limit(4'd4)) dut (
    .clk     (clk),
    .rst     (rst),
    .imem_in (imem_in),
    .imem_out(imem_out),
    .dmem_in (dmem_in),
    .dmem_out(dmem_out),
    .mem_in  (mem_in),
    .mem_out (mem_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memval(logic [31:0] a);
    case (a)
      32'h100:  return 32'h0000_0013;
      32'h200:  return 32'h0010_0093;
      32'h204:  return 32'h2222_2222;
      32'h210:  return 32'h9999_9999;
      32'h300:  return 32'h5555_5555;
      32'h304:  return 32'h4444_4444;
      32'h108:  return 32'h6666_6666;
      32'h10C:  return 32'hABCD_0001;
      32'h8000: return 32'hDEAD_BEEF;
      32'h8004: return 32'h7777_7777;
      32'h8008: return 32'h8888_8888;
      32'h9000: return 32'h1111_1111;
      32'hA000: return 32'h3333_3333;
      default:  return 32'hBAD0_BAD0;
    endcase
  endfunction

  task automatic check(bit ok, string name, string detail);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_i(logic [31:0] a);
    imem_in = '0;
    imem_in.mem_valid = 1'b1;
    imem_in.mem_addr = a;
  endtask

  task automatic set_d(logic [31:0] a, logic [31:0] wd,
                       logic [3:0] ws, logic f);
    dmem_in = '0;
    dmem_in.mem_valid = 1'b1;
    dmem_in.mem_instr = 1'b1;
    dmem_in.mem_fence = f;
    dmem_in.mem_addr = a;
    dmem_in.mem_wdata = wd;
    dmem_in.mem_wstrb = ws;
  endtask

  task automatic ex_iss(int c, logic ins, logic f, logic [31:0] a,
                        logic [31:0] wd, logic [3:0] ws);
    exp_iss.push_back('{c, ins, f, a, wd, ws});
  endtask

  // memory model: answers each issue lat cycles later
  always @(negedge clk)
    if (rst && mem_in.mem_valid)
      mq.push_back('{cyc + lat, memval(mem_in.mem_addr)});

  always @(posedge clk) begin
    #1;
    mem_out = '0;
    if (mq.size() > 0 && mq[0].cyc == cyc) begin
      mem_out.mem_ready = 1'b1;
      mem_out.mem_rdata = mq[0].data;
      void'(mq.pop_front());
    end
  end

  // issue monitor
  always @(negedge clk) begin : mon_iss
    iss_t e;
    if (rst && mem_in.mem_valid) begin
      if (exp_iss.size() == 0) begin
        check(0, "issue", $sformatf(
          "unexpected issue addr %h at cyc %0d",
          mem_in.mem_addr, cyc));
      end else begin
        e = exp_iss.pop_front();
        check(e.cyc == cyc && e.addr == mem_in.mem_addr
              && e.instr == mem_in.mem_instr
              && e.fence == mem_in.mem_fence
              && e.wdata == mem_in.mem_wdata
              && e.wstrb == mem_in.mem_wstrb, "issue",
          $sformatf({"got cyc %0d addr %h i%b f%b wd %h ws %h,",
                     " exp cyc %0d addr %h i%b f%b wd %h ws %h"},
            cyc, mem_in.mem_addr, mem_in.mem_instr,
            mem_in.mem_fence, mem_in.mem_wdata,
            mem_in.mem_wstrb, e.cyc, e.addr, e.instr,
            e.fence, e.wdata, e.wstrb));
      end
    end
  end

  // response monitors
  always @(negedge clk) begin : mon_rsp
    rsp_t e;
    if (rst && imem_out.mem_ready) begin
      if (exp_i.size() == 0) begin
        check(0, "imem_rsp", $sformatf(
          "unexpected rdata %h at cyc %0d",
          imem_out.mem_rdata, cyc));
      end else begin
        e = exp_i.pop_front();
        check(e.cyc == cyc && e.data == imem_out.mem_rdata,
          "imem_rsp", $sformatf(
          "got cyc %0d rdata %h, exp cyc %0d rdata %h",
          cyc, imem_out.mem_rdata, e.cyc, e.data));
      end
    end
    if (rst && dmem_out.mem_ready) begin
      if (exp_d.size() == 0) begin
        check(0, "dmem_rsp", $sformatf(
          "unexpected rdata %h at cyc %0d",
          dmem_out.mem_rdata, cyc));
      end else begin
        e = exp_d.pop_front();
        check(e.cyc == cyc && e.data == dmem_out.mem_rdata,
          "dmem_rsp", $sformatf(
          "got cyc %0d rdata %h, exp cyc %0d rdata %h",
          cyc, dmem_out.mem_rdata, e.cyc, e.data));
      end
    end
    if (rst && mem_out.mem_ready)
      check(imem_out.mem_ready ? dmem_out == '0
                               : imem_out == '0,
        "excl", $sformatf("cyc %0d imem_out %h dmem_out %h",
          cyc, imem_out, dmem_out));
  end

  initial begin : stim
    int t;
    tick(2);
    @(negedge clk);
    check(mem_in == '0, "rst_mem_in",
      $sformatf("got %h exp 0", mem_in));
    check(imem_out == '0, "rst_imem_out",
      $sformatf("got %h exp 0", imem_out));
    check(dmem_out == '0, "rst_dmem_out",
      $sformatf("got %h exp 0", dmem_out));

    // single fetch
    tick();
    rst = 1'b1;
    t = cyc;
    set_i(32'h100);
    ex_iss(t, 1, 0, 32'h100, 0, 0);
    exp_i.push_back('{t + 2, 32'h0000_0013});
    tick();
    imem_in = '0;
    tick(5);

    // contention, dmem wins
    t = cyc;
    set_i(32'h200);
    set_d(32'h8000, 32'hCAFE_F00D, 4'hF, 0);
    ex_iss(t, 0, 0, 32'h8000, 32'hCAFE_F00D, 4'hF);
    exp_d.push_back('{t + 2, 32'hDEAD_BEEF});
    ex_iss(t + 2, 1, 0, 32'h200, 0, 0);
    exp_i.push_back('{t + 4, 32'h0010_0093});
    tick();
    imem_in = '0;
    dmem_in = '0;
    tick(6);

    // starvation guard
    t = cyc;
    set_i(32'h210);
    set_d(32'h9000, 32'h0, 4'h0, 0);
    for (int k = 0; k < 4; k++) begin
      ex_iss(t + 2 * k, 0, 0, 32'h9000, 0, 0);
      exp_d.push_back('{t + 2 * k + 2, 32'h1111_1111});
    end
    ex_iss(t + 8, 1, 0, 32'h210, 0, 0);
    exp_i.push_back('{t + 10, 32'h9999_9999});
    ex_iss(t + 10, 0, 0, 32'h9000, 0, 0);
    exp_d.push_back('{t + 12, 32'h1111_1111});
    ex_iss(t + 12, 1, 0, 32'h204, 0, 0);
    exp_i.push_back('{t + 14, 32'h2222_2222});
    tick();
    imem_in = '0;
    tick(8);
    dmem_in = '0;
    tick();
    set_i(32'h204);
    tick();
    imem_in = '0;
    tick(6);

    // overwrite while pending
    lat = 3;
    t = cyc;
    set_d(32'hA000, 32'h0, 4'h0, 0);
    ex_iss(t, 0, 0, 32'hA000, 0, 0);
    exp_d.push_back('{t + 3, 32'h3333_3333});
    ex_iss(t + 3, 1, 0, 32'h304, 0, 0);
    exp_i.push_back('{t + 6, 32'h4444_4444});
    tick();
    dmem_in = '0;
    set_i(32'h300);
    tick();
    set_i(32'h304);
    tick();
    imem_in = '0;
    tick(6);
    lat = 2;

    // back-to-back, and a request on its response cycle
    t = cyc;
    set_i(32'h108);
    ex_iss(t, 1, 0, 32'h108, 0, 0);
    exp_i.push_back('{t + 2, 32'h6666_6666});
    tick();
    imem_in = '0;
    set_d(32'h8004, 32'h1234_5678, 4'h3, 1);
    ex_iss(t + 2, 0, 1, 32'h8004, 32'h1234_5678, 4'h3);
    exp_d.push_back('{t + 4, 32'h7777_7777});
    tick();
    dmem_in = '0;
    tick(2);
    set_d(32'h8008, 32'h0, 4'h0, 0);
    ex_iss(t + 4, 0, 0, 32'h8008, 0, 0);
    exp_d.push_back('{t + 6, 32'h8888_8888});
    tick();
    dmem_in = '0;
    tick(5);

    // reset while busy
    lat = 3;
    t = cyc;
    set_i(32'h10C);
    ex_iss(t, 1, 0, 32'h10C, 0, 0);
    tick();
    imem_in = '0;
    rst = 1'b0;
    set_d(32'hA004, 32'h0, 4'hF, 0);
    @(negedge clk);
    check(mem_in == '0 && imem_out == '0 && dmem_out == '0,
      "rst_busy", $sformatf("mem_in %h imem_out %h dmem_out %h",
        mem_in, imem_out, dmem_out));
    tick();
    rst = 1'b1;
    dmem_in = '0;
    @(negedge clk);
    check(mem_in == '0 && imem_out == '0 && dmem_out == '0,
      "post_rst", $sformatf("mem_in %h imem_out %h dmem_out %h",
        mem_in, imem_out, dmem_out));
    tick();
    @(negedge clk);
    check(!imem_out.mem_ready && !dmem_out.mem_ready,
      "late_ready", $sformatf("imem ready %b dmem ready %b",
        imem_out.mem_ready, dmem_out.mem_ready));
    tick(4);
    lat = 2;

    tick(3);
    check(exp_iss.size() == 0, "iss_left",
      $sformatf("%0d issues missing, exp 0", exp_iss.size()));
    check(exp_i.size() == 0, "imem_left",
      $sformatf("%0d responses missing, exp 0", exp_i.size()));
    check(exp_d.size() == 0, "dmem_left",
      $sformatf("%0d responses missing, exp 0", exp_d.size()));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
